// File: rtl/bldc_velocity_loop.sv
// bldc_velocity_loop
//   Closed-loop velocity core for one BLDC axis. Counts signed encoder ticks
//   over a fixed sample window, IIR-filters the count, runs a saturating PI
//   law with anti-windup and sequences rotor alignment before closed-loop run.
//
//   Optional feature macro: BLDC_VEL_STALL_DETECT_EN
//     defined   : saturated-gain / zero-tick windows are counted; after
//                 STALL_WINDOWS consecutive ones the loop enters FAULT.
//     undefined : no stall counter, FAULT unreachable, fault tied low.
//
// Ports
//   clk                       in  system clock, rising edge
//   reset                     in  asynchronous active-low reset
//   enable                    in  1 = run loop, 0 = return to IDLE
//   desired_velocity          in  signed setpoint, ticks per window
//   encoder_change            in  one-cycle pulse per encoder tick
//   encoder_direction         in  1 = forward (+1), 0 = reverse (-1)
//   measured_velocity         out signed filtered velocity
//   output_gain               out signed gain to commutation
//   sample_valid              out one-cycle pulse when output_gain updates in RUN
//   reset_encoder_count       out high throughout ALIGN
//   apply_initial_commutation out high throughout ALIGN
//   fault                     out high in FAULT
module bldc_velocity_loop #(
  parameter int VEL_W         = 16,
  parameter int GAIN_W        = 12,
  parameter int SAMPLE_CYCLES = 50000,
  parameter int FILT_SHIFT    = 2,
  parameter int KP            = 10,
  parameter int KI            = 1,
  parameter int ALIGN_CYCLES  = 100000,
  parameter int ALIGN_GAIN    = 512,
  parameter int STALL_WINDOWS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [VEL_W-1:0]  desired_velocity,
  input  logic              encoder_change,
  input  logic              encoder_direction,
  output logic [VEL_W-1:0]  measured_velocity,
  output logic [GAIN_W-1:0] output_gain,
  output logic              sample_valid,
  output logic              reset_encoder_count,
  output logic              apply_initial_commutation,
  output logic              fault
);

  localparam int FW    = VEL_W + 1;   // filter / error width
  localparam int AW    = VEL_W + 34;  // PI accumulation width, no overflow for 32-bit gains
  localparam int WIN_W = $clog2(SAMPLE_CYCLES);
  localparam int ALN_W = $clog2(ALIGN_CYCLES + 1);

  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(SAMPLE_CYCLES - 1);
  localparam logic [ALN_W-1:0] ALIGN_LAST = ALN_W'(ALIGN_CYCLES - 1);

  localparam logic signed [VEL_W-1:0] TICK_MAX   = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] TICK_MIN   = -TICK_MAX;
  localparam logic signed [VEL_W:0]   TICK_MAX_E = {2'b00, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W:0]   TICK_MIN_E = -TICK_MAX_E;
  localparam logic signed [VEL_W:0]   TICK_ONE   = {{VEL_W{1'b0}}, 1'b1};

  localparam logic signed [GAIN_W-1:0] GMAX_G       = {1'b0, {(GAIN_W-1){1'b1}}};
  localparam logic signed [GAIN_W-1:0] GMIN_G       = -GMAX_G;
  localparam logic signed [AW-1:0]     GMAX_A       = AW'(GMAX_G);
  localparam logic signed [AW-1:0]     GMIN_A       = -GMAX_A;
  localparam logic signed [AW-1:0]     KP_A         = AW'(KP);
  localparam logic signed [AW-1:0]     KI_A         = AW'(KI);
  localparam logic signed [GAIN_W-1:0] ALIGN_GAIN_G = GAIN_W'(ALIGN_GAIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_RUN,
    S_FAULT
  } state_e;

  state_e                     state_q, state_d;
  logic [ALN_W-1:0]           align_cnt_q, align_cnt_d;
  logic [WIN_W-1:0]           win_cnt_q, win_cnt_d;
  logic signed [VEL_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic signed [FW-1:0]       filt_q, filt_d;
  logic                       vld1_q, vld1_d;
  logic signed [GAIN_W-1:0]   integ_q, integ_d;
  logic signed [GAIN_W-1:0]   gain_q, gain_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       align_q, align_d;

  logic                       win_end;
  logic signed [VEL_W:0]      tick_delta;
  logic signed [VEL_W:0]      tick_sum;
  logic signed [VEL_W-1:0]    raw_sat;
  logic signed [FW:0]         raw_e;
  logic signed [FW:0]         filt_e;
  logic signed [FW:0]         diff;
  logic signed [FW-1:0]       filt_next;
  logic signed [FW-1:0]       des_e;
  logic signed [FW-1:0]       err;
  logic signed [AW-1:0]       err_a;
  logic signed [AW-1:0]       integ_a;
  logic signed [AW-1:0]       u;
  logic signed [AW-1:0]       i_sum;
  logic                       u_hi, u_lo;
  logic                       windup;
  logic signed [GAIN_W-1:0]   gain_pi;
  logic signed [GAIN_W-1:0]   integ_pi;
  logic                       stall_hit;

  // Tick accumulation, filter and PI arithmetic.
  always_comb begin
    win_end = (state_q == S_RUN) && (win_cnt_q == WIN_LAST);

    // A tick arriving on the window-end cycle is folded into the closing window.
    tick_delta = '0;
    if (encoder_change) begin
      tick_delta = encoder_direction ? TICK_ONE : '1;
    end
    tick_sum = {tick_cnt_q[VEL_W-1], tick_cnt_q} + tick_delta;
    if (tick_sum > TICK_MAX_E) begin
      raw_sat = TICK_MAX;
    end else if (tick_sum < TICK_MIN_E) begin
      raw_sat = TICK_MIN;
    end else begin
      raw_sat = tick_sum[VEL_W-1:0];
    end

    raw_e     = {{2{raw_sat[VEL_W-1]}}, raw_sat};
    filt_e    = {filt_q[FW-1], filt_q};
    diff      = raw_e - filt_e;
    filt_next = filt_q + FW'(diff >>> FILT_SHIFT);

    des_e   = {desired_velocity[VEL_W-1], desired_velocity};
    err     = des_e - filt_q;
    err_a   = AW'(err);
    integ_a = AW'(integ_q);
    u       = KP_A * err_a + integ_a;
    u_hi    = u > GMAX_A;
    u_lo    = u < GMIN_A;
    if (u_hi) begin
      gain_pi = GMAX_G;
    end else if (u_lo) begin
      gain_pi = GMIN_G;
    end else begin
      gain_pi = u[GAIN_W-1:0];
    end

    i_sum = integ_a + KI_A * err_a;
    if (i_sum > GMAX_A) begin
      integ_pi = GMAX_G;
    end else if (i_sum < GMIN_A) begin
      integ_pi = GMIN_G;
    end else begin
      integ_pi = i_sum[GAIN_W-1:0];
    end

    // Freeze the integrator only when it would push further into saturation.
    windup = (u_hi || u_lo) && (err != '0) && (u[AW-1] == err[FW-1]);
  end

`ifdef BLDC_VEL_STALL_DETECT_EN
  localparam int STL_W = $clog2(STALL_WINDOWS + 1);

  logic [STL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_win;
  logic             fault_q, fault_d;

  always_comb begin
    stall_win   = win_end && (raw_sat == '0) && ((gain_q == GMAX_G) || (gain_q == GMIN_G));
    stall_hit   = stall_win && (stall_cnt_q == STL_W'(STALL_WINDOWS - 1));
    stall_cnt_d = stall_cnt_q;
    if ((state_q != S_RUN) || !enable) begin
      stall_cnt_d = '0;
    end else if (win_end) begin
      stall_cnt_d = stall_win ? stall_cnt_q + 1'b1 : '0;
    end
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign stall_hit = 1'b0;
  assign fault     = 1'b0;
`endif

  // Next-state and datapath register updates, keyed on the state being entered
  // so that every registered output lines up with state_q.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (enable) state_d = S_ALIGN;
      S_ALIGN: if (align_cnt_q == ALIGN_LAST) state_d = S_RUN;
      S_RUN:   if (stall_hit) state_d = S_FAULT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (!enable) begin
      state_d = S_IDLE;
    end

    align_cnt_d    = '0;
    win_cnt_d      = '0;
    tick_cnt_d     = '0;
    filt_d         = filt_q;
    vld1_d         = 1'b0;
    integ_d        = integ_q;
    gain_d         = '0;
    sample_valid_d = 1'b0;
    align_d        = (state_d == S_ALIGN);

    unique case (state_d)
      S_IDLE: begin
        filt_d  = '0;
        integ_d = '0;
      end
      S_ALIGN: begin
        if (state_q == S_ALIGN) begin
          align_cnt_d = align_cnt_q + 1'b1;
        end
        integ_d = '0;
        gain_d  = ALIGN_GAIN_G;
      end
      S_RUN: begin
        if (state_q != S_RUN) begin
          // Closed loop starts from a zero gain and empty integrator.
          integ_d = '0;
        end else begin
          win_cnt_d  = win_end ? '0 : win_cnt_q + 1'b1;
          tick_cnt_d = win_end ? '0 : raw_sat;
          gain_d     = gain_q;
          if (win_end) begin
            filt_d = filt_next;
            vld1_d = 1'b1;
          end
          if (vld1_q) begin
            gain_d         = gain_pi;
            sample_valid_d = 1'b1;
            if (!windup) begin
              integ_d = integ_pi;
            end
          end
        end
      end
      S_FAULT: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      align_cnt_q    <= '0;
      win_cnt_q      <= '0;
      tick_cnt_q     <= '0;
      filt_q         <= '0;
      vld1_q         <= 1'b0;
      integ_q        <= '0;
      gain_q         <= '0;
      sample_valid_q <= 1'b0;
      align_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      align_cnt_q    <= align_cnt_d;
      win_cnt_q      <= win_cnt_d;
      tick_cnt_q     <= tick_cnt_d;
      filt_q         <= filt_d;
      vld1_q         <= vld1_d;
      integ_q        <= integ_d;
      gain_q         <= gain_d;
      sample_valid_q <= sample_valid_d;
      align_q        <= align_d;
    end
  end

  assign measured_velocity         = filt_q[VEL_W-1:0];
  assign output_gain               = gain_q;
  assign sample_valid              = sample_valid_q;
  assign reset_encoder_count       = align_q;
  assign apply_initial_commutation = align_q;

endmodule

// File: tb/tb_bldc_velocity_loop.sv
// Testbench for bldc_velocity_loop: directed window-by-window stimulus with a
// reference model whose predicted samples are queued at each window end and
// compared when sample_valid pulses.
module tb_bldc_velocity_loop;

  localparam int VEL_W  = 16;
  localparam int GAIN_W = 12;
  localparam int SC     = 100;
  localparam int FS     = 0;
  localparam int KP     = 10;
  localparam int KI     = 1;
  localparam int ALN    = 10;
  localparam int AGAIN  = 512;
  localparam int SW     = 8;
  localparam int GMAX   = 2047;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [VEL_W-1:0]  desired_velocity;
  logic              encoder_change;
  logic              encoder_direction;
  logic [VEL_W-1:0]  measured_velocity;
  logic [GAIN_W-1:0] output_gain;
  logic              sample_valid;
  logic              reset_encoder_count;
  logic              apply_initial_commutation;
  logic              fault;

  bldc_velocity_loop #(
    .VEL_W(VEL_W), .GAIN_W(GAIN_W), .SAMPLE_CYCLES(SC), .FILT_SHIFT(FS),
    .KP(KP), .KI(KI), .ALIGN_CYCLES(ALN), .ALIGN_GAIN(AGAIN), .STALL_WINDOWS(SW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .desired_velocity(desired_velocity),
    .encoder_change(encoder_change), .encoder_direction(encoder_direction),
    .measured_velocity(measured_velocity), .output_gain(output_gain),
    .sample_valid(sample_valid), .reset_encoder_count(reset_encoder_count),
    .apply_initial_commutation(apply_initial_commutation), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int gain;
    int meas;
    int end_cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int  m_filt, m_integ, m_gain, m_stall;
  bit  m_faulted;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int clampg(input int v);
    if (v > GMAX) return GMAX;
    if (v < -GMAX) return -GMAX;
    return v;
  endfunction

  // Scoreboard consumer: every sample_valid pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (reset === 1'b1 && sample_valid === 1'b1) begin
      chk("sample_expected", (sbq.size() > 0) ? 1 : 0, 1);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("gain", $signed(output_gain), mon_e.gain);
        chk("measured", $signed(measured_velocity), mon_e.meas);
        chk("latency", cyc - mon_e.end_cyc, 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic model_clear();
    m_filt = 0; m_integ = 0; m_gain = 0; m_stall = 0; m_faulted = 0;
  endtask

  // Entered #1 after a rising edge with the DUT in IDLE.
  task automatic do_align();
    int cnt;
    cnt = 0;
    enable = 1'b1;
    for (int k = 0; k <= ALN; k++) begin
      @(posedge clk); #1;
      if (apply_initial_commutation === 1'b1) cnt++;
      if (k < ALN) begin
        chk("align_gain", $signed(output_gain), AGAIN);
        chk("align_rst_enc", reset_encoder_count, 1);
      end else begin
        chk("run_entry_gain", $signed(output_gain), 0);
        chk("run_entry_rst_enc", reset_encoder_count, 0);
      end
    end
    chk("align_len", cnt, ALN);
    model_clear();
  endtask

  // One full window: nf forward then nr reverse ticks, optional forward tick
  // on the window-end cycle. Entered #1 after the edge that zeroed the window.
  task automatic run_window(input int nf, input int nr, input bit endtick, input int des);
    int raw, err, u, g;
    bit fexp;
    for (int c = 0; c < SC; c++) begin
      if (c == 2) desired_velocity = VEL_W'(des);
      encoder_change    = (c < nf + nr) || (endtick && c == SC - 1);
      encoder_direction = (c < nf) || (c == SC - 1);
      @(posedge clk); #1;
    end
    encoder_change = 1'b0;
    raw = nf - nr + (endtick ? 1 : 0);
    fexp = 1'b0;
`ifdef BLDC_VEL_STALL_DETECT_EN
    if (raw == 0 && (m_gain == GMAX || m_gain == -GMAX)) m_stall++;
    else m_stall = 0;
    fexp = (m_stall == SW);
`endif
    chk("fault", fault, fexp);
    if (fexp) begin
      m_faulted = 1'b1;
      m_gain = 0;
      chk("fault_gain", $signed(output_gain), 0);
    end else begin
      m_filt = m_filt + ((raw - m_filt) >>> FS);
      err = des - m_filt;
      u = KP * err + m_integ;
      g = clampg(u);
      if (!((u > GMAX || u < -GMAX) && ((u > 0 && err > 0) || (u < 0 && err < 0))))
        m_integ = clampg(m_integ + KI * err);
      m_gain = g;
      sbq.push_back('{gain: g, meas: m_filt, end_cyc: cyc});
    end
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    desired_velocity = '0;
    encoder_change = 1'b0;
    encoder_direction = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gain", $signed(output_gain), 0);
    chk("rst_meas", $signed(measured_velocity), 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_rst_enc", reset_encoder_count, 0);
    chk("rst_align", apply_initial_commutation, 0);
    chk("rst_fault", fault, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_gain", $signed(output_gain), 0);
    chk("idle_align", apply_initial_commutation, 0);

    do_align();
    // Tracking at setpoint, then setpoint steps, reverse ticks, end-cycle tick.
    repeat (3) run_window(20, 0, 1'b0, 20);
    repeat (3) run_window(20, 0, 1'b0, 30);
    run_window(0, 5, 1'b0, -10);
    run_window(3, 0, 1'b1, 10);
    // Positive saturation with anti-windup, recovery, negative saturation.
    repeat (3) run_window(0, 0, 1'b0, 1000);
    run_window(0, 0, 1'b0, 10);
    repeat (2) run_window(0, 0, 1'b0, -1000);
    run_window(5, 0, 1'b0, 15);

    // Asynchronous reset in the middle of a running window.
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_gain", $signed(output_gain), 0);
    chk("async_rst_meas", $signed(measured_velocity), 0);
    chk("async_rst_valid", sample_valid, 0);
    chk("async_rst_align", apply_initial_commutation, 0);
    chk("async_rst_fault", fault, 0);
    chk("sb_drained_before_reset", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    do_align();
    run_window(20, 0, 1'b0, 25);

    // enable dropped mid-window: window discarded, filter cleared.
    repeat (30) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk); #1;
    chk("disable_gain", $signed(output_gain), 0);
    chk("disable_meas", $signed(measured_velocity), 0);
    chk("disable_align", apply_initial_commutation, 0);
    repeat (5) @(posedge clk);
    #1;

    // Saturated with no motion: stall detection when built in.
    do_align();
    for (int w = 0; w < 12; w++) begin
      if (!m_faulted) run_window(0, 0, 1'b0, 1000);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("hold_gain", $signed(output_gain), m_faulted ? 0 : GMAX);
    chk("hold_fault", fault, m_faulted ? 1 : 0);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("exit_fault", fault, 0);
    chk("exit_gain", $signed(output_gain), 0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
